// File: rtl/relu_pkg.sv
// ============================================================================
// Module : relu_pkg
// Brief  : Shared types and constants for the ReLU-backward layer sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package relu_pkg;

  localparam int FP_W      = 32;
  localparam int DEF_WIDTH = 8;

  typedef logic [DEF_WIDTH*FP_W-1:0] fp_vec_t;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_RD_REQ  = 3'd1,
    SEQ_RD_WAIT = 3'd2,
    SEQ_COMPUTE = 3'd3,
    SEQ_WR_REQ  = 3'd4,
    SEQ_FIN     = 3'd5
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/relu_seq_lat_cnt.sv
// ============================================================================
// Module : relu_seq_lat_cnt
// Brief  : Loadable datapath-latency down-counter with terminal flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module relu_seq_lat_cnt #(
  parameter int LAT_W = 4,
  parameter int LAT   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  logic [LAT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LAT_W'(LAT);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Flags the cycle in which the count steps down to zero.
  assign o_zero = (r_count == LAT_W'(1));

endmodule

`default_nettype wire

// File: rtl/relu_backward_seq.sv
// ============================================================================
// Module : relu_backward_seq
// Brief  : Streams NUM vectors src mem -> ReLU-backward datapath -> dst mem.
//          Optional stall counter port: RELU_BACKWARD_SEQ_STALL_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module relu_backward_seq
  import relu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int DP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             id,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      src_base,
  input  logic [ADDR_W-1:0]      dst_base,
  input  logic [CNT_W-1:0]       num_vecs,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             done_id,
  output logic                   rd_req,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_gnt,
  input  logic                   rd_valid,
  input  logic [WIDTH*FP_W-1:0]  rd_data,
  output logic [WIDTH*FP_W-1:0]  dp_in_vec,
  input  logic [WIDTH*FP_W-1:0]  dp_out_vec,
  output logic                   wr_req,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [WIDTH*FP_W-1:0]  wr_data,
  input  logic                   wr_gnt
`ifdef RELU_BACKWARD_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int LAT_W = 4;

  seq_state_t              r_state;
  seq_state_t              w_state_next;
  logic [ADDR_W-1:0]       r_src;
  logic [ADDR_W-1:0]       r_dst;
  logic [CNT_W-1:0]        r_num;
  logic [CNT_W-1:0]        r_idx;
  logic [7:0]              r_id;
  logic [WIDTH*FP_W-1:0]   r_dp_in;
  logic [WIDTH*FP_W-1:0]   r_wr_data;

  logic                    w_accept;
  logic                    w_rd_cap;
  logic                    w_wr_done;
  logic                    w_lat_zero;
  logic                    w_compute;
  logic [CNT_W-1:0]        w_idx_next;

  assign w_accept   = (r_state == SEQ_IDLE) && start;
  assign w_rd_cap   = ((r_state == SEQ_RD_REQ) && rd_gnt && rd_valid) ||
                      ((r_state == SEQ_RD_WAIT) && rd_valid);
  assign w_wr_done  = (r_state == SEQ_WR_REQ) && wr_gnt;
  assign w_compute  = (r_state == SEQ_COMPUTE);
  assign w_idx_next = r_idx + 1'b1;

  relu_seq_lat_cnt #(
    .LAT_W (LAT_W),
    .LAT   (DP_LAT)
  ) u_lat_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_rd_cap),
    .i_en   (w_compute),
    .o_zero (w_lat_zero)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEQ_IDLE:    if (start)      w_state_next = (num_vecs == '0) ? SEQ_FIN : SEQ_RD_REQ;
      SEQ_RD_REQ:  if (rd_gnt)     w_state_next = rd_valid ? SEQ_COMPUTE : SEQ_RD_WAIT;
      SEQ_RD_WAIT: if (rd_valid)   w_state_next = SEQ_COMPUTE;
      SEQ_COMPUTE: if (w_lat_zero) w_state_next = SEQ_WR_REQ;
      // idx is compared after increment so a full 2^CNT_W-1 job never wraps.
      SEQ_WR_REQ:  if (wr_gnt)     w_state_next = (w_idx_next == r_num) ? SEQ_FIN : SEQ_RD_REQ;
      SEQ_FIN:                     w_state_next = SEQ_IDLE;
      default:                     w_state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= SEQ_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_num     <= '0;
      r_idx     <= '0;
      r_id      <= '0;
      r_dp_in   <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_src <= src_base;
        r_dst <= dst_base;
        r_num <= num_vecs;
        r_id  <= id;
        r_idx <= '0;
      end
      if (w_rd_cap) begin
        r_dp_in <= rd_data;
      end
      if (w_compute && w_lat_zero) begin
        r_wr_data <= dp_out_vec;
      end
      if (w_wr_done) begin
        r_idx <= w_idx_next;
      end
    end
  end

  assign busy      = (r_state != SEQ_IDLE) && (r_state != SEQ_FIN);
  assign done      = (r_state == SEQ_FIN);
  assign done_id   = done ? r_id : 8'h00;
  assign rd_req    = (r_state == SEQ_RD_REQ);
  assign wr_req    = (r_state == SEQ_WR_REQ);
  assign rd_addr   = r_src + ADDR_W'(r_idx);
  assign wr_addr   = r_dst + ADDR_W'(r_idx);
  assign dp_in_vec = r_dp_in;
  assign wr_data   = r_wr_data;

`ifdef RELU_BACKWARD_SEQ_STALL_CNT_EN
  logic [31:0] r_stall;
  logic        w_stall;

  assign w_stall = ((r_state == SEQ_RD_REQ) && !rd_gnt) ||
                   (r_state == SEQ_RD_WAIT) ||
                   ((r_state == SEQ_WR_REQ) && !wr_gnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (w_accept) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_relu_backward_seq.sv
// ============================================================================
// Module : tb_relu_backward_seq
// Brief  : Scoreboard bench for relu_backward_seq with memory/datapath models.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_relu_backward_seq;
  import relu_pkg::*;

  localparam int WIDTH  = DEF_WIDTH;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;
  localparam int DP_LAT = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       id = '0;
  logic             start = 1'b0;
  logic [15:0]      src_base = '0;
  logic [15:0]      dst_base = '0;
  logic [15:0]      num_vecs = '0;
  logic             busy, done, rd_req, wr_req, rd_gnt, wr_gnt;
  logic             rd_valid = 1'b0;
  logic [7:0]       done_id;
  logic [15:0]      rd_addr, wr_addr;
  fp_vec_t          rd_data = '0;
  fp_vec_t          dp_in_vec, dp_out_vec, wr_data;
`ifdef RELU_BACKWARD_SEQ_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int rd_dly = 0, wr_dly = 0;
  int rd_cnt = 0, wr_cnt = 0;
  int busy_cnt = 0;

  logic [15:0] rd_q[$];
  logic [15:0] wr_addr_q[$];
  fp_vec_t     wr_data_q[$];
  logic [7:0]  done_id_q[$];
  int          done_busy_q[$];

  always #5 clk = ~clk;

  relu_backward_seq #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .DP_LAT(DP_LAT)
  ) dut (
    .clk(clk), .reset(reset), .id(id), .start(start),
    .src_base(src_base), .dst_base(dst_base), .num_vecs(num_vecs),
    .busy(busy), .done(done), .done_id(done_id),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .dp_in_vec(dp_in_vec), .dp_out_vec(dp_out_vec),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt)
`ifdef RELU_BACKWARD_SEQ_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // Sign pattern of each source vector and its hand-derived pass mask.
  function automatic logic [7:0] neg_mask(input int k);
    case (k)
      0: return 8'hA5;
      1: return 8'h00;
      2: return 8'hF0;
      default: return 8'h69;
    endcase
  endfunction

  function automatic logic [7:0] keep_mask(input int k);
    case (k)
      0: return 8'h5A;
      1: return 8'hFF;
      2: return 8'h0F;
      default: return 8'h96;
    endcase
  endfunction

  function automatic fp_vec_t src_vec(input logic [15:0] addr);
    fp_vec_t    v;
    logic [7:0] m;
    int         k;
    k = int'(addr[1:0]);
    m = neg_mask(k);
    for (int j = 0; j < WIDTH; j++)
      v[32*j +: 32] = {m[j], 8'h40, 7'(k), 16'(j) * 16'h0101};
    return v;
  endfunction

  function automatic fp_vec_t exp_vec(input logic [15:0] addr);
    fp_vec_t    v;
    logic [7:0] m;
    v = src_vec(addr);
    m = keep_mask(int'(addr[1:0]));
    for (int j = 0; j < WIDTH; j++)
      if (!m[j]) v[32*j +: 32] = 32'h0;
    return v;
  endfunction

  function automatic fp_vec_t relu_dp(input fp_vec_t x);
    fp_vec_t v;
    for (int j = 0; j < WIDTH; j++)
      v[32*j +: 32] = x[32*j+31] ? 32'h0 : x[32*j +: 32];
    return v;
  endfunction

  assign dp_out_vec = relu_dp(dp_in_vec);
  assign rd_gnt     = rd_req && (rd_cnt >= rd_dly);
  assign wr_gnt     = wr_req && (wr_cnt >= wr_dly);

  always @(posedge clk) begin
    rd_cnt   <= (rd_req && !rd_gnt) ? rd_cnt + 1 : 0;
    wr_cnt   <= (wr_req && !wr_gnt) ? wr_cnt + 1 : 0;
    rd_valid <= rd_req && rd_gnt;
    rd_data  <= src_vec(rd_addr);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  initial begin
    logic        prev_rd_stall, prev_wr_stall;
    logic [15:0] prev_rd_addr, prev_wr_addr;
    fp_vec_t     prev_wr_data;
    prev_rd_stall = 1'b0;
    prev_wr_stall = 1'b0;
    prev_rd_addr  = '0;
    prev_wr_addr  = '0;
    prev_wr_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt      = 0;
        prev_rd_stall = 1'b0;
        prev_wr_stall = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (prev_rd_stall && rd_req) chk("rd_addr_stable", rd_addr, prev_rd_addr);
        if (prev_wr_stall && wr_req) begin
          chk("wr_addr_stable", wr_addr, prev_wr_addr);
          chk("wr_data_stable", wr_data, prev_wr_data);
        end
        if (rd_req && rd_gnt) begin
          if (rd_q.size() == 0) chk("unexpected_rd", 1'b1, 1'b0);
          else chk("rd_addr", rd_addr, rd_q.pop_front());
        end
        if (wr_req && wr_gnt) begin
          if (wr_addr_q.size() == 0) chk("unexpected_wr", 1'b1, 1'b0);
          else begin
            chk("wr_addr", wr_addr, wr_addr_q.pop_front());
            chk("wr_data", wr_data, wr_data_q.pop_front());
          end
        end
        if (done) begin
          if (done_id_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
          else begin
            chk("done_id", done_id, done_id_q.pop_front());
            chk("busy_cycles", busy_cnt, done_busy_q.pop_front());
            chk("busy_low_at_done", busy, 1'b0);
          end
          busy_cnt = 0;
        end
        prev_rd_stall = rd_req && !rd_gnt;
        prev_wr_stall = wr_req && !wr_gnt;
        prev_rd_addr  = rd_addr;
        prev_wr_addr  = wr_addr;
        prev_wr_data  = wr_data;
      end
    end
  end

  task automatic push_job(input logic [7:0] jid, input logic [15:0] sb, input logic [15:0] db,
                          input int n, input int busy_exp);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(sb + 16'(i));
      wr_addr_q.push_back(db + 16'(i));
      wr_data_q.push_back(exp_vec(sb + 16'(i)));
    end
    done_id_q.push_back(jid);
    done_busy_q.push_back(busy_exp);
  endtask

  task automatic start_job(input logic [7:0] jid, input logic [15:0] sb, input logic [15:0] db,
                           input logic [15:0] n);
    @(posedge clk); #1;
    id = jid; src_base = sb; dst_base = db; num_vecs = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((rd_q.size() != 0 || wr_addr_q.size() != 0 || done_id_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", (c >= budget), 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic flush_sb();
    rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    done_id_q.delete(); done_busy_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    logic found;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_rd_addr", rd_addr, 16'h0);
    chk("rst_wr_addr", wr_addr, 16'h0);
    chk("rst_done_id", done_id, 8'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic 3-vector job, zero-wait grants
    push_job(8'hA1, 16'h0010, 16'h0040, 3, 12);
    start_job(8'hA1, 16'h0010, 16'h0040, 16'd3);
    drain(200);

    // Zero length
    push_job(8'h11, 16'h0000, 16'h0000, 0, 0);
    start_job(8'h11, 16'h0000, 16'h0000, 16'd0);
    chk("zero_done_next_cycle", done, 1'b1);
    drain(50);

    // Backpressure
    rd_dly = 4; wr_dly = 2;
    push_job(8'h55, 16'h0020, 16'h0050, 1, 10);
    start_job(8'h55, 16'h0020, 16'h0050, 16'd1);
    drain(200);
`ifdef RELU_BACKWARD_SEQ_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, 32'd7);
`endif
    rd_dly = 0; wr_dly = 0;

    // Address wrap-around
    push_job(8'h66, 16'hFFFF, 16'h0080, 2, 8);
    start_job(8'h66, 16'hFFFF, 16'h0080, 16'd2);
    drain(200);

    // Start while busy, with inputs changed mid-job
    push_job(8'h22, 16'h0020, 16'h0060, 2, 8);
    start_job(8'h22, 16'h0020, 16'h0060, 16'd2);
    repeat (2) @(posedge clk); #1;
    id = 8'h33; src_base = 16'h0099; dst_base = 16'h0099; num_vecs = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain(200);
    repeat (10) @(posedge clk);

    // Reset during WR_REQ of vector 1
    wr_dly = 3;
    push_job(8'h44, 16'h0030, 16'h0070, 3, 0);
    start_job(8'h44, 16'h0030, 16'h0070, 16'd3);
    c = 0; found = 1'b0;
    while (!found && c < 200) begin
      @(negedge clk);
      c++;
      if (wr_req && wr_addr == 16'h0071) found = 1'b1;
    end
    chk("reached_wr1", found, 1'b1);
    #2;
    flush_sb();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_done_id", done_id, 8'h0);
    chk("mid_rst_rd_req", rd_req, 1'b0);
    chk("mid_rst_wr_req", wr_req, 1'b0);
    chk("mid_rst_rd_addr", rd_addr, 16'h0);
    chk("mid_rst_wr_addr", wr_addr, 16'h0);
    chk("mid_rst_wr_data", wr_data, 256'h0);
    chk("mid_rst_dp_in", dp_in_vec, 256'h0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    wr_dly = 0;
    push_job(8'h45, 16'h0030, 16'h0070, 2, 8);
    start_job(8'h45, 16'h0030, 16'h0070, 16'd2);
    drain(200);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
